uart_tx_scheduler: RTL and testbench

Round-robin scheduler that shares one UART transmit line between several byte sources. It arbitrates among up to NUM_REQ requesters using a valid/ready handshake and latches the granted byte. It then serializes the byte as an 8N1 frame, with its own bit-period counter derived from the system clock. It sits between the system's byte producers and the UART TX pin, taking the place of a free-running TX baud clock with a sequenced, shared one.

---
 rtl/uart_tx_scheduler_if.sv | 12 +
 rtl/uart_tx_scheduler.sv | 124 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_if.sv
// Request bus shared by the byte producers and the UART TX scheduler:
// per-requester valid flags, packed bytes, and the one-hot accept strobe.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;

  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter feeding a single 8N1 UART transmitter; the winning
// byte is latched on the accept edge and shifted out LSB first.
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 1668,
  localparam int GW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  uart_tx_scheduler_if.slave req,
  output logic               tx,
  output logic               busy,
  output logic [GW-1:0]      grant_id,
  output logic               frame_done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] CNT_MAX = 16'(CLKS_PER_BIT - 1);

  state_t             r_state;
  logic [15:0]        r_cnt;
  logic [2:0]         r_bit;
  logic [7:0]         r_shift;
  logic [GW-1:0]      r_last;

  logic               w_found;
  logic [GW-1:0]      w_winner;
  logic [GW-1:0]      w_idx;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_bit_end;

  assign w_bit_end = (r_cnt == CNT_MAX);

  // Search starts just after the last grant, so that requester is checked last.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = GW'((int'(r_last) + k) % NUM_REQ);
      if (!w_found && req.req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (reset_n && (r_state == IDLE) && w_found) begin
      w_ready[w_winner] = 1'b1;
    end
  end

  assign req.req_ready = w_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_last     <= GW'(NUM_REQ - 1);
      tx         <= 1'b1;
      busy       <= 1'b0;
      grant_id   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_shift  <= req.req_data[8*w_winner +: 8];
            r_last   <= w_winner;
            grant_id <= w_winner;
            tx       <= 1'b0;
            busy     <= 1'b1;
            r_cnt    <= '0;
            r_state  <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            tx      <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
            r_state <= DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
              tx      <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              tx      <= r_shift[0];
              r_shift <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_cnt      <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized bench for uart_tx_scheduler: a cycle-level frame model, a UART
// receiver on tx, and directed scenarios for arbitration and reset behaviour.
module tb_uart_tx_scheduler;
  localparam int NR  = 4;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       tx;
  logic       busy;
  logic [1:0] grant_id;
  logic       frame_done;

  uart_tx_scheduler_if #(.NUM_REQ(NR)) bus ();

  uart_tx_scheduler #(.NUM_REQ(NR), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (bus),
    .tx        (tx),
    .busy      (busy),
    .grant_id  (grant_id),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: frame position counted in cycles since the accept edge.
  int          m_last = NR - 1;
  bit          m_active = 1'b0;
  int          m_k = 0;
  logic [7:0]  m_byte = '0;
  int          m_gid = 0;
  bit          m_fd = 1'b0;
  int          m_w;
  logic [NR-1:0] exp_rdy;
  int          q_gnt[$];
  logic [7:0]  q_rx[$];

  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    return f[pos];
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_active = 1'b0; m_last = NR - 1; m_gid = 0; m_fd = 1'b0;
      end
      exp_rdy = '0;
      m_w = -1;
      if (reset_n && !m_active) begin
        for (int k = 1; k <= NR; k++) begin
          if (m_w < 0 && bus.req_valid[(m_last + k) % NR]) m_w = (m_last + k) % NR;
        end
        if (m_w >= 0) exp_rdy[m_w] = 1'b1;
      end
      chk("req_ready", bus.req_ready, exp_rdy);
      chk("tx", tx, m_active ? frame_bit(m_byte, m_k / CPB) : 1'b1);
      chk("busy", busy, m_active);
      chk("frame_done", frame_done, m_fd);
      chk("grant_id", grant_id, m_gid);
      for (int i = 0; i < NR; i++) if (bus.req_ready[i]) q_gnt.push_back(i);
      @(posedge clk);
      m_fd = 1'b0;
      if (!reset_n) begin
        m_active = 1'b0; m_last = NR - 1; m_gid = 0;
      end else if (m_w >= 0) begin
        m_byte = bus.req_data[8*m_w +: 8];
        m_active = 1'b1; m_k = 0; m_last = m_w; m_gid = m_w;
      end else if (m_active) begin
        m_k++;
        if (m_k == 10 * CPB) begin
          m_active = 1'b0;
          m_fd = 1'b1;
        end
      end
    end
  end

  // Independent UART receiver sampling mid-bit.
  bit         rx_on = 1'b0;
  int         rx_t = 0;
  logic [7:0] rx_sh = '0;
  always @(negedge clk) begin
    if (!reset_n) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (tx == 1'b0) begin
        rx_on = 1'b1;
        rx_t = 0;
      end
    end else begin
      rx_t++;
      if (rx_t >= 24 && rx_t <= 136 && (rx_t - 8) % 16 == 0) rx_sh = {tx, rx_sh[7:1]};
      if (rx_t == 152) begin
        chk("rx_stop_bit", tx, 1'b1);
        q_rx.push_back(rx_sh);
        rx_on = 1'b0;
      end
    end
  end

  function automatic int rx_last();
    if (q_rx.size() == 0) return -1;
    return int'(q_rx[q_rx.size()-1]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.req_ready == '0 && n < 50);
    if (bus.req_ready == '0) chk({tag, "_ready_timeout"}, 0, 1);
  endtask

  task automatic wait_fd(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 400);
    if (!frame_done) chk({tag, "_done_timeout"}, 0, 1);
  endtask

  int b2b_exp[5] = '{'h11, 'h22, 'h33, 'h44, 'h11};
  int fair_exp[3] = '{2, 3, 1};
  int n;
  logic [7:0] v;

  initial begin
    reset_n = 1'b0;
    bus.req_valid = '1;
    bus.req_data = {8'h44, 8'h33, 8'h22, 8'hA5};
    repeat (5) tick();
    @(negedge clk);
    chk("rst_ready", bus.req_ready, 4'b0000);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    wait_fd("a5", n);
    chk("a5_edges", n - 1, 160);
    chk("a5_grant", grant_id, 0);
    chk("a5_rx", rx_last(), 8'hA5);

    // back-to-back from a fresh reset
    tick();
    reset_n = 1'b0;
    tick(); tick();
    bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.req_valid = '1;
    q_rx.delete(); q_gnt.delete();
    reset_n = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_fd("b2b", n);
      chk("b2b_ready_with_done", (bus.req_ready != '0), 1);
    end
    tick();
    bus.req_valid = '0;
    wait_fd("b2b_last", n);
    chk("b2b_frames", q_rx.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < q_rx.size()) chk($sformatf("b2b_byte%0d", i), q_rx[i], b2b_exp[i]);
      if (i < q_gnt.size()) chk($sformatf("b2b_grant%0d", i), q_gnt[i], i % NR);
    end

    // fairness: just-granted requester goes to the back
    tick();
    q_gnt.delete();
    bus.req_valid = 4'b0100;
    wait_ready("fair");
    tick();
    bus.req_valid = 4'b1010;
    chk("fair_gid_a", grant_id, 2);
    wait_fd("fair_a", n);
    tick();
    chk("fair_gid_b", grant_id, 3);
    wait_fd("fair_b", n);
    tick();
    bus.req_valid = '0;
    chk("fair_gid_c", grant_id, 1);
    wait_fd("fair_c", n);
    chk("fair_grants", q_gnt.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < q_gnt.size()) chk($sformatf("fair_grant%0d", i), q_gnt[i], fair_exp[i]);

    // data changed after the accept edge must not affect the frame
    tick();
    v = 8'($urandom);
    bus.req_data[23:16] = v;
    bus.req_valid = 4'b0100;
    wait_ready("hold");
    tick();
    bus.req_data[23:16] = ~v;
    bus.req_valid = '0;
    wait_fd("hold", n);
    chk("hold_rx", rx_last(), v);

    // reset in the middle of data bit 3
    tick();
    bus.req_data[7:0] = 8'($urandom);
    bus.req_valid = 4'b0001;
    wait_ready("abort");
    tick();
    bus.req_valid = '0;
    repeat (70) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", busy, 1'b0);
    bus.req_valid = 4'b0101;
    v = 8'($urandom);
    bus.req_data[7:0] = v;
    repeat (3) tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort_rel_ready", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    wait_fd("abort_resume", n);
    chk("abort_resume_rx", rx_last(), v);

    // random traffic
    for (int c = 0; c < 2000; c++) begin
      tick();
      bus.req_valid = 4'($urandom);
      bus.req_data = $urandom;
    end
    tick();
    bus.req_valid = '0;
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("final_idle", busy, 1'b0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
